// File: rtl/val2_shifter_pipe_if.sv
// Operand-2 generator bus: issue-side beat fields plus the result handshake.
interface val2_shifter_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             imm;
  logic             select;
  logic [11:0]      shift_operand;
  logic [WIDTH-1:0] rm;
  logic [7:0]       rs;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] val_2;
  logic             carry_out;

  modport master (
    output in_valid, imm, select, shift_operand, rm, rs, carry_in, out_ready,
    input  in_ready, out_valid, val_2, carry_out
  );

  modport slave (
    input  in_valid, imm, select, shift_operand, rm, rs, carry_in, out_ready,
    output in_ready, out_valid, val_2, carry_out
  );
endinterface

// File: rtl/val2_shifter_pipe.sv
// ARM operand-2 shifter, two register stages, result 2 cycles after accept.
// Valid/ready throughout: a stalled output holds, stage 1 buffers one beat, then in_ready drops.
module val2_shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  val2_shifter_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_ROT   = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_RRX   = 2'd3
  } mode_e;

  localparam logic [7:0] W8     = 8'(WIDTH);
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  logic             s1_valid;
  mode_e            s1_mode;
  logic [1:0]       s1_type;
  logic [7:0]       s1_amt;
  logic [WIDTH-1:0] s1_val;
  logic             s1_cin;

  logic             out_valid_q;
  logic [WIDTH-1:0] val_2_q;
  logic             carry_q;

  logic             in_ready;
  logic             accept;
  logic             s1_adv;

  assign in_ready      = !s1_valid || !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && in_ready;
  assign s1_adv        = s1_valid && (!out_valid_q || bus.out_ready);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.val_2     = val_2_q;
  assign bus.carry_out = carry_q;

  // Stage 1 decode: every form is reduced to a mode, an 8-bit amount and a source value.
  mode_e            d_mode;
  logic [7:0]       d_amt;
  logic [WIDTH-1:0] d_val;
  logic [1:0]       d_type;
  logic [4:0]       imm_n;

  assign d_type = bus.shift_operand[6:5];
  assign imm_n  = bus.shift_operand[11:7];

  always_comb begin
    d_mode = MODE_SHIFT;
    d_amt  = '0;
    d_val  = bus.rm;
    if (bus.select) begin
      d_mode = MODE_PASS;
      d_val  = WIDTH'(bus.shift_operand);
    end else if (bus.imm) begin
      d_mode = MODE_ROT;
      d_val  = WIDTH'(bus.shift_operand[7:0]);
      d_amt  = {3'b000, bus.shift_operand[11:8], 1'b0};
    end else if (bus.shift_operand[4]) begin
      d_amt = bus.rs;
    end else if (imm_n != 5'd0) begin
      d_amt = {3'b000, imm_n};
    end else if (d_type == SH_ROR) begin
      d_mode = MODE_RRX;
    end else if (d_type != SH_LSL) begin
      // LSR #0 / ASR #0 stand for a full-width shift.
      d_amt = W8;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_PASS;
      s1_type  <= '0;
      s1_amt   <= '0;
      s1_val   <= '0;
      s1_cin   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (accept) begin
        s1_mode <= d_mode;
        s1_type <= d_type;
        s1_amt  <= d_amt;
        s1_val  <= d_val;
        s1_cin  <= bus.carry_in;
      end
    end
  end

  // Stage 2: barrel shifts use the low SHW bits; the 8-bit amount picks the range rule.
  logic [SHW-1:0]   amt_lo;
  logic [SHW-1:0]   amt_m1;
  logic [SHW-1:0]   amt_neg;
  logic             amt_lt;
  logic             amt_eq;
  logic             msb;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] asr;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] res_v;
  logic             res_c;

  assign amt_lo  = s1_amt[SHW-1:0];
  assign amt_m1  = amt_lo - SHW'(1);
  assign amt_neg = SHW'(0) - amt_lo;
  assign amt_lt  = s1_amt < W8;
  assign amt_eq  = s1_amt == W8;
  assign msb     = s1_val[WIDTH-1];
  assign shl     = s1_val << amt_lo;
  assign shr     = s1_val >> amt_lo;
  assign asr     = $unsigned($signed(s1_val) >>> amt_lo);
  assign rot     = shr | (s1_val << amt_neg);

  always_comb begin
    res_v = s1_val;
    res_c = s1_cin;
    case (s1_mode)
      MODE_PASS: begin
        res_v = s1_val;
        res_c = s1_cin;
      end
      MODE_ROT: begin
        res_v = rot;
        res_c = (s1_amt == 8'd0) ? s1_cin : rot[WIDTH-1];
      end
      MODE_RRX: begin
        res_v = {s1_cin, s1_val[WIDTH-1:1]};
        res_c = s1_val[0];
      end
      default: begin
        if (s1_amt != 8'd0) begin
          case (s1_type)
            SH_LSL: begin
              res_v = amt_lt ? shl : '0;
              res_c = amt_lt ? s1_val[amt_neg] : (amt_eq && s1_val[0]);
            end
            SH_LSR: begin
              res_v = amt_lt ? shr : '0;
              res_c = amt_lt ? s1_val[amt_m1] : (amt_eq && msb);
            end
            SH_ASR: begin
              res_v = amt_lt ? asr : {WIDTH{msb}};
              res_c = amt_lt ? s1_val[amt_m1] : msb;
            end
            default: begin
              res_v = rot;
              res_c = (amt_lo == '0) ? msb : s1_val[amt_m1];
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      val_2_q     <= '0;
      carry_q     <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (s1_adv) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (s1_adv && !flush) begin
        val_2_q <= res_v;
        carry_q <= res_c;
      end
    end
  end

endmodule
